// File: rtl/buf_mode_arb.sv
// Buffer-mode arbiter: grants a shared buffer to bus, DMA or Ethernet through a
// one-cycle GUARD state so the address mux settles before any grant is raised.
module buf_mode_arb #(
  parameter logic [15:0] TMO = 16'd1024
) (
  input  logic       wb_clk_i,
  input  logic       rst_n_i,
  input  logic       bus_req_i,
  input  logic       dma_req_i,
  input  logic       eth_req_i,
  input  logic       ovr_clr_i,
  output logic       bus_gnt_o,
  output logic       dma_gnt_o,
  output logic       eth_gnt_o,
  output logic [1:0] adr_mode_o,
  output logic       busy_o,
  output logic       eth_ovr_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GUARD   = 3'd1;
  localparam logic [2:0] S_OWN_BUS = 3'd2;
  localparam logic [2:0] S_OWN_DMA = 3'd3;
  localparam logic [2:0] S_OWN_ETH = 3'd4;

  localparam logic [1:0] M_BUS = 2'b00;
  localparam logic [1:0] M_DMA = 2'b01;
  localparam logic [1:0] M_ETH = 2'b10;

  logic [2:0]  state_q, state_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [1:0]  adr_q, adr_d;
  logic [15:0] wait_q, wait_d;
  logic        ovr_q, ovr_d;
  logic        ovr_set;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    adr_d   = adr_q;
    case (state_q)
      S_IDLE: begin
        if (eth_req_i || dma_req_i || bus_req_i) begin
          state_d = S_GUARD;
          if (eth_req_i)      tgt_d = M_ETH;
          else if (dma_req_i) tgt_d = M_DMA;
          else                tgt_d = M_BUS;
          adr_d = tgt_d;
        end
      end
      S_GUARD: begin
        // Ownership is entered even if the target request dropped meanwhile.
        case (tgt_q)
          M_BUS:   state_d = S_OWN_BUS;
          M_DMA:   state_d = S_OWN_DMA;
          default: state_d = S_OWN_ETH;
        endcase
      end
      S_OWN_BUS: if (!bus_req_i) state_d = S_IDLE;
      S_OWN_DMA: if (!dma_req_i) state_d = S_IDLE;
      S_OWN_ETH: if (!eth_req_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_d  = '0;
    ovr_set = 1'b0;
    if (eth_req_i && !eth_gnt_o) begin
      if (wait_q != TMO) wait_d = wait_q + 16'd1;
      else               wait_d = wait_q;
      // Flag only on the edge the count arrives at TMO, so a clear while still
      // saturated is honoured.
      ovr_set = (wait_q != TMO) && (wait_q + 16'd1 == TMO);
    end
    ovr_d = ovr_set | (ovr_q & ~ovr_clr_i);
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      tgt_q   <= M_BUS;
      adr_q   <= M_BUS;
      wait_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      adr_q   <= adr_d;
      wait_q  <= wait_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus_gnt_o  = (state_q == S_OWN_BUS);
  assign dma_gnt_o  = (state_q == S_OWN_DMA);
  assign eth_gnt_o  = (state_q == S_OWN_ETH);
  assign busy_o     = (state_q != S_IDLE);
  assign adr_mode_o = adr_q;
  assign eth_ovr_o  = ovr_q;

endmodule
